// File: rtl/mio_uart_pkg.sv
// Shared definitions for the MIO UART transmitter: FSM encoding, status bit
// positions and the baud divider calculation.
package mio_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_FULL    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/mio_uart_if.sv
// Bus-side connection of the UART transmitter: write strobe, data, overflow
// clear and the status word returned to the read-data mux.
interface mio_uart_if;
    logic        uart_we;
    logic [7:0]  wdata;
    logic        ovf_clr;
    logic [31:0] status;

    modport master (output uart_we, wdata, ovf_clr, input status);
    modport slave  (input uart_we, wdata, ovf_clr, output status);
endinterface

// File: rtl/mio_uart_fifo.sv
// Synchronous byte FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module mio_uart_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [3:0]        count,
    output logic              full,
    output logic              empty,
    output logic              ovf_evt
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == 4'(DEPTH));
    assign empty   = (count == 4'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign ovf_evt = push && full && !do_pop;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mio_uart_tx.sv
// Memory-mapped UART transmitter: bus writes fill a byte FIFO that is sent 8N1,
// or 8E1 when the UART_PARITY_EN macro is defined.
module mio_uart_tx
    import mio_uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    mio_uart_if.slave bus,
    output logic      tx
);
    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);

    logic [7:0]    fifo_rdata;
    logic [3:0]    count;
    logic          full, empty, ovf_evt, pop;
    logic          ovf, busy, nempty_p1;
    logic [31:0]   status_w;
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shift, shift_nx;
    logic          tx_nx;
`ifdef UART_PARITY_EN
    logic          par, par_nx;
`endif

    mio_uart_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(8)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.uart_we),
        .pop     (pop),
        .wdata   (bus.wdata),
        .rdata   (fifo_rdata),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .ovf_evt (ovf_evt)
    );

    assign busy = (state != ST_IDLE);

    always_comb begin
        status_w                        = '0;
        status_w[STAT_BUSY]             = busy;
        status_w[STAT_EMPTY]            = empty;
        status_w[STAT_FULL]             = full;
        status_w[STAT_OVF]              = ovf;
        status_w[STAT_CNT_LSB +: 4]     = count;
    end
    assign bus.status = status_w;

    // Serialiser next-state: IDLE waits one cycle of registered non-empty before popping
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        tx_nx      = tx;
        pop        = 1'b0;
`ifdef UART_PARITY_EN
        par_nx     = par;
`endif
        case (state)
            ST_IDLE: begin
                tx_nx = 1'b1;
                if (nempty_p1 && !empty) begin
                    pop      = 1'b1;
                    shift_nx = fifo_rdata;
                    cnt_nx   = CW'(DIV - 1);
                    tx_nx    = 1'b0;
                    state_nx = ST_START;
`ifdef UART_PARITY_EN
                    par_nx   = ^fifo_rdata;
`endif
                end
            end
            ST_START: begin
                if (cnt == '0) begin
                    state_nx   = ST_DATA;
                    tx_nx      = shift[0];
                    bit_idx_nx = 3'd0;
                    cnt_nx     = CW'(DIV - 1);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt == '0) begin
                    cnt_nx = CW'(DIV - 1);
                    if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_nx = ST_PARITY;
                        tx_nx    = par;
`else
                        state_nx = ST_STOP;
                        tx_nx    = 1'b1;
`endif
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                        shift_nx   = shift >> 1;
                        tx_nx      = shift[1];
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (cnt == '0) begin
                    state_nx = ST_STOP;
                    tx_nx    = 1'b1;
                    cnt_nx   = CW'(DIV - 1);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
`endif
            ST_STOP: begin
                tx_nx = 1'b1;
                if (cnt == '0) state_nx = ST_IDLE;
                else           cnt_nx   = cnt - CW'(1);
            end
            default: begin
                state_nx = ST_IDLE;
                tx_nx    = 1'b1;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            tx        <= 1'b1;
            ovf       <= 1'b0;
            nempty_p1 <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_idx   <= bit_idx_nx;
            tx        <= tx_nx;
            nempty_p1 <= !empty;
            if (ovf_evt)          ovf <= 1'b1;
            else if (bus.ovf_clr) ovf <= 1'b0;
        end
    end

    // Data registers
    always_ff @(posedge clk) begin
        shift <= shift_nx;
`ifdef UART_PARITY_EN
        par   <= par_nx;
`endif
    end
endmodule
